// File: rtl/branch_control_if.sv
// Fetch-control bundle between the hazard/execute side and the PC sequencer.
// The master drives branch resolution and stall; the slave returns PC and pipeline controls.
interface branch_control_if #(
  parameter int unsigned bus = 32
);
  logic           stall;
  logic           br_valid;
  logic           br_taken;
  logic [bus-1:0] br_target;
  logic [bus-1:0] pc;
  logic           fetch_en;
  logic           flush;
  logic           nop;
  logic [bus-1:0] taken_count;

  modport master (
    output stall, br_valid, br_taken, br_target,
    input  pc, fetch_en, flush, nop, taken_count
  );

  modport slave (
    input  stall, br_valid, br_taken, br_target,
    output pc, fetch_en, flush, nop, taken_count
  );
endinterface

// File: rtl/branch_control.sv
// PC sequencer with taken-branch redirect, fixed-length flush window and a
// saturating taken-branch counter.
module branch_control #(
  parameter int unsigned    bus          = 32,
  parameter int unsigned    PC_STEP      = 4,
  parameter int unsigned    FLUSH_CYCLES = 2,
  parameter logic [bus-1:0] RESET_PC     = '0
) (
  input logic               clk,
  input logic               rst,
  branch_control_if.slave   bif
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [bus-1:0] STEP       = bus'(PC_STEP);
  localparam logic [2:0]     BCNT_START = 3'(FLUSH_CYCLES - 1);

  state_t         state;
  logic [2:0]     bcnt;
  logic [bus-1:0] pc_q;
  logic [bus-1:0] count_q;

  logic take;
  logic fetch_en_c;
  logic flush_c;
  logic nop_c;

  // Branches seen while flushing come from squashed instructions.
  assign take = (state == RUN) && bif.br_valid && bif.br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state   <= RUN;
      bcnt    <= '0;
      count_q <= '0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            pc_q  <= bif.br_target;
            state <= FLUSH;
            bcnt  <= BCNT_START;
            if (count_q != '1) count_q <= count_q + 1'b1;
          end else if (!bif.stall) begin
            pc_q <= pc_q + STEP;
          end
        end
        FLUSH: begin
          pc_q <= pc_q + STEP;
          if (bcnt == '0) begin
            state <= RUN;
          end else begin
            bcnt <= bcnt - 3'd1;
          end
        end
        default: begin
          state <= RUN;
          bcnt  <= '0;
        end
      endcase
    end
  end

  // flush is combinational in the accepting cycle so the wrong-path fetch is squashed.
  always_comb begin
    fetch_en_c = 1'b0;
    flush_c    = 1'b1;
    nop_c      = 1'b1;
    if (!rst) begin
      if (state == FLUSH) begin
        fetch_en_c = 1'b1;
        flush_c    = 1'b1;
        nop_c      = 1'b1;
      end else begin
        fetch_en_c = !bif.stall || take;
        flush_c    = take;
        nop_c      = 1'b0;
      end
    end
  end

  assign bif.pc          = pc_q;
  assign bif.taken_count = count_q;
  assign bif.fetch_en    = fetch_en_c;
  assign bif.flush       = flush_c;
  assign bif.nop         = nop_c;

endmodule

// File: tb/tb_branch_control.sv
// Directed vector bench for branch_control: a 32-bit instance driven from a
// cycle table, plus a 4-bit instance for counter saturation and single-cycle flush.
module tb_branch_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst4;

  branch_control_if #(.bus(32)) bif  ();
  branch_control_if #(.bus(4))  bif4 ();

  branch_control #(
    .bus(32), .PC_STEP(4), .FLUSH_CYCLES(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .bif(bif)
  );

  branch_control #(
    .bus(4), .PC_STEP(4), .FLUSH_CYCLES(1), .RESET_PC(4'h0)
  ) dut4 (
    .clk(clk), .rst(rst4), .bif(bif4)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        fe;
    logic        fl;
    logic        nop;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic r, logic s, logic bv, logic bt, logic [31:0] tgt,
                              logic [31:0] pc, logic fe, logic fl, logic nop, logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.stall = s; v.bv = bv; v.bt = bt; v.tgt = tgt;
    v.pc = pc; v.fe = fe; v.fl = fl; v.nop = nop; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive4(input logic bv, input logic bt, input logic [3:0] tgt);
    bif4.stall     = 1'b0;
    bif4.br_valid  = bv;
    bif4.br_taken  = bt;
    bif4.br_target = tgt;
  endtask

  task automatic check4(input int idx, input logic [3:0] pc, input logic fe, input logic fl,
                        input logic nop, input logic [3:0] cnt);
    n_vec++;
    chk("small_pc",    idx, {28'h0, bif4.pc},          {28'h0, pc});
    chk("small_fe",    idx, {31'h0, bif4.fetch_en},    {31'h0, fe});
    chk("small_flush", idx, {31'h0, bif4.flush},       {31'h0, fl});
    chk("small_nop",   idx, {31'h0, bif4.nop},         {31'h0, nop});
    chk("small_count", idx, {28'h0, bif4.taken_count}, {28'h0, cnt});
  endtask

  initial begin
    //          rst stl bv bt target        pc            fe fl nop cnt
    vt[0]  = mk(1, 1, 1, 1, 32'h200,       32'h0,        0, 1, 1, 0);  // branch during reset dropped
    vt[1]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 32'h0,         32'h8,        1, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 32'h0,         32'hC,        1, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 32'h0,         32'h10,       1, 0, 0, 0);
    vt[6]  = mk(1, 0, 0, 0, 32'h0,         32'h14,       0, 1, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 0);
    vt[9]  = mk(0, 0, 1, 1, 32'h40,        32'h8,        1, 1, 0, 0);  // taken at pc=8
    vt[10] = mk(0, 1, 1, 1, 32'h200,       32'h40,       1, 1, 1, 1);  // branch+stall in flush ignored
    vt[11] = mk(0, 0, 0, 0, 32'h0,         32'h44,       1, 1, 1, 1);
    vt[12] = mk(0, 0, 0, 0, 32'h0,         32'h48,       1, 0, 0, 1);
    vt[13] = mk(0, 0, 1, 0, 32'h300,       32'h4C,       1, 0, 0, 1);  // not-taken is sequential
    vt[14] = mk(0, 1, 0, 0, 32'h0,         32'h50,       0, 0, 0, 1);
    vt[15] = mk(0, 1, 1, 0, 32'h300,       32'h50,       0, 0, 0, 1);
    vt[16] = mk(0, 1, 0, 0, 32'h0,         32'h50,       0, 0, 0, 1);
    vt[17] = mk(0, 1, 1, 1, 32'h80,        32'h50,       1, 1, 0, 1);  // branch beats stall
    vt[18] = mk(0, 1, 0, 0, 32'h0,         32'h80,       1, 1, 1, 2);
    vt[19] = mk(0, 0, 0, 0, 32'h0,         32'h84,       1, 1, 1, 2);
    vt[20] = mk(0, 0, 1, 1, 32'hFFFFFFFC,  32'h88,       1, 1, 0, 2);
    vt[21] = mk(0, 0, 0, 0, 32'h0,         32'hFFFFFFFC, 1, 1, 1, 3);
    vt[22] = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 1, 1, 3);  // wrapped
    vt[23] = mk(0, 0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 3);
    vt[24] = mk(0, 0, 1, 1, 32'h100,       32'h8,        1, 1, 0, 3);
    vt[25] = mk(1, 0, 0, 0, 32'h0,         32'h100,      0, 1, 1, 4);  // reset in first flush cycle
    vt[26] = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 0);
    vt[27] = mk(0, 0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 0);

    rst  = 1'b1;
    rst4 = 1'b1;
    bif.stall = 1'b0; bif.br_valid = 1'b0; bif.br_taken = 1'b0; bif.br_target = '0;
    drive4(1'b0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst           = vt[i].rst;
      bif.stall     = vt[i].stall;
      bif.br_valid  = vt[i].bv;
      bif.br_taken  = vt[i].bt;
      bif.br_target = vt[i].tgt;
      #2;
      n_vec++;
      chk("pc",          i, bif.pc,                   vt[i].pc);
      chk("fetch_en",    i, {31'h0, bif.fetch_en},    {31'h0, vt[i].fe});
      chk("flush",       i, {31'h0, bif.flush},       {31'h0, vt[i].fl});
      chk("nop",         i, {31'h0, bif.nop},         {31'h0, vt[i].nop});
      chk("taken_count", i, bif.taken_count,          vt[i].cnt);
    end

    // 4-bit instance: 20 taken branches, each followed by its single flush cycle
    @(negedge clk);
    rst4 = 1'b0;
    drive4(1'b0, 1'b0, 4'h0);
    #2;
    check4(0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive4(1'b1, 1'b1, 4'(i));
      #2;
      check4(2 * i + 1, bif4.pc, 1'b1, 1'b1, 1'b0, (i > 15) ? 4'd15 : 4'(i));
      @(negedge clk);
      drive4(1'b0, 1'b0, 4'h0);
      #2;
      check4(2 * i + 2, 4'(i), 1'b1, 1'b1, 1'b1, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    @(negedge clk);
    #2;
    check4(41, 4'h7, 1'b1, 1'b0, 1'b0, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
